// File: rtl/mc_capture_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for the
// multicycle result capture block.
package mc_capture_pkg;

  localparam logic [8:0] ADDR_CTRL   = 9'd0;
  localparam logic [8:0] ADDR_STATUS = 9'd1;
  localparam logic [8:0] ADDR_SKIP   = 9'd2;
  localparam int         BUF_SEL_BIT = 8;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_CLEAR_BIT   = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       done,
                                              input logic [8:0] count);
    logic [31:0] s;
    s = '0;
    s[STATUS_BUSY_BIT]          = busy;
    s[STATUS_DONE_BIT]          = done;
    s[STATUS_COUNT_LSB +: 9]    = count;
    return s;
  endfunction

endpackage

// File: rtl/mc_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port,
// read-first so a read of the entry being written returns its old contents.
module mc_capture_ram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             div_clock,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: no reset on the array or read register, so the tools can map this
  // onto block RAM; the top masks the read register until a buffer read.
  always_ff @(posedge div_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/mc_result_capture.sv
// Captures DEPTH consecutive samples of a multicycle stage output after a
// programmable skip, with an Avalon-MM slave for control and readback.
module mc_result_capture
  import mc_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             div_clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [8:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cap_state_e       r_state;
  logic [15:0]      r_skip;
  logic [15:0]      r_skip_cnt;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             r_rd_buf;
  logic [31:0]      r_rd_reg;

  logic             w_wr_ctrl;
  logic             w_start;
  logic             w_clear;
  logic             w_buf_hit;
  logic             w_we;
  logic [WIDTH-1:0] w_ram_q;
  logic [31:0]      w_reg_rdata;
  logic             w_unused;

  assign w_wr_ctrl = write && (address == ADDR_CTRL);
  assign w_start   = w_wr_ctrl && writedata[CTRL_START_BIT];
  assign w_clear   = w_wr_ctrl && writedata[CTRL_CLEAR_BIT];
  assign w_buf_hit = address[BUF_SEL_BIT] && ({1'b0, address[7:0]} < 9'(DEPTH));
  assign w_unused  = ^writedata[31:16];

  // Reset or clear in the same cycle must suppress the pending sample write.
  assign w_we = (r_state == ST_CAPTURE) && !reset && !w_clear;

  assign busy = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);

  mc_capture_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .div_clock (div_clock),
    .i_wr_en   (w_we),
    .i_wr_addr (r_count[AW-1:0]),
    .i_wr_data (data_in),
    .i_rd_en   (read && w_buf_hit),
    .i_rd_addr (address[AW-1:0]),
    .o_rd_data (w_ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which also gives read-before-write on the bus.
  always_ff @(posedge div_clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_skip     <= '0;
      r_skip_cnt <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
    end else begin
      if (write && (address == ADDR_SKIP)) r_skip <= writedata[15:0];

      if (w_clear) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_start) begin
              r_state    <= (r_skip == 16'd0) ? ST_CAPTURE : ST_ARMED;
              r_skip_cnt <= r_skip;
              r_count    <= '0;
              r_done     <= 1'b0;
            end
          end
          ST_ARMED: begin
            r_skip_cnt <= r_skip_cnt - 16'd1;
            if (r_skip_cnt == 16'd1) r_state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            r_count <= r_count + CW'(1);
            if (r_count == CW'(DEPTH - 1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: default assignment first keeps this decode free of inferred latches.
  always_comb begin
    w_reg_rdata = '0;
    case (address)
      ADDR_STATUS: w_reg_rdata = pack_status(busy, r_done, 9'(r_count));
      ADDR_SKIP:   w_reg_rdata = {16'd0, r_skip};
      default:     w_reg_rdata = '0;
    endcase
  end

  // Read source and register data only move on a read, so readdata holds.
  always_ff @(posedge div_clock) begin
    if (reset) begin
      r_rd_buf <= 1'b0;
      r_rd_reg <= '0;
    end else if (read) begin
      r_rd_buf <= w_buf_hit;
      r_rd_reg <= w_reg_rdata;
    end
  end

  assign readdata = r_rd_buf ? 32'(w_ram_q) : r_rd_reg;

endmodule

// File: tb/tb_mc_result_capture.sv
// Directed bench: a default-sized capture block plus a 12-bit, 32-entry one
// sharing the bus, each scenario checked against hand-computed values.
module tb_mc_result_capture;

  logic        div_clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic [11:0] data_w12 = '0;
  logic [8:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata_w12;
  logic        busy, busy_w12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 div_clock = ~div_clock;

  mc_result_capture #(.WIDTH(32), .DEPTH(64)) u_dut (
    .div_clock (div_clock), .reset (reset), .data_in (data_in),
    .address (address), .read (read), .write (write),
    .writedata (writedata), .readdata (readdata), .busy (busy)
  );

  mc_result_capture #(.WIDTH(12), .DEPTH(32)) u_dut_w12 (
    .div_clock (div_clock), .reset (reset), .data_in (data_w12),
    .address (address), .read (read), .write (write),
    .writedata (writedata), .readdata (readdata_w12), .busy (busy_w12)
  );

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    @(negedge div_clock); address = a; writedata = d; write = 1'b1;
    @(negedge div_clock); write = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [31:0] d);
    @(negedge div_clock); address = a; read = 1'b1;
    @(negedge div_clock); read = 1'b0; d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(negedge div_clock);
    reset = 1'b0;
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
    bus_read(9'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_skip got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_reg_access;
    logic [31:0] d;
    @(negedge div_clock);
    address = 9'd2; writedata = 32'hABCD_1234; write = 1'b1; read = 1'b1;
    @(negedge div_clock); write = 1'b0; read = 1'b0;
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rw_same_cycle got=%h exp=%h", readdata, 32'h0); end
    bus_read(9'd2, d);
    n_checks++; if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL skip_16bit got=%h exp=%h", d, 32'h0000_1234); end
    address = 9'd1;
    repeat (3) @(negedge div_clock);
    n_checks++; if (readdata !== 32'h0000_1234) begin n_fail++; $display("FAIL readdata_hold got=%h exp=%h", readdata, 32'h0000_1234); end
    bus_read(9'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_addr got=%h exp=%h", d, 32'h0); end
    bus_write(9'd2, 32'h0);
  endtask

  task automatic test_skip0_ramp;
    logic [31:0] d;
    bus_write(9'd0, 32'h1);
    for (int i = 0; i < 64; i++) begin
      data_in = 32'h10 + 32'(i);
      @(negedge div_clock);
    end
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hDEAD_0000 + 32'(i);
      @(negedge div_clock);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_done got=%b exp=0", busy); end
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0000_4002) begin n_fail++; $display("FAIL ramp_status got=%h exp=%h", d, 32'h0000_4002); end
    for (int i = 0; i < 64; i++) begin
      bus_read(9'(256 + i), d);
      n_checks++; if (d !== 32'h10 + 32'(i)) begin n_fail++; $display("FAIL ramp_entry%0d got=%h exp=%h", i, d, 32'h10 + 32'(i)); end
    end
  endtask

  task automatic test_skip5;
    logic [31:0] d;
    int busy_cycles;
    busy_cycles = 0;
    bus_write(9'd2, 32'd5);
    bus_write(9'd0, 32'h1);
    for (int i = 0; i < 100; i++) begin
      data_in = 32'(i);
      if (busy) busy_cycles++;
      @(negedge div_clock);
    end
    n_checks++; if (busy_cycles !== 69) begin n_fail++; $display("FAIL skip5_busy_cycles got=%0d exp=%0d", busy_cycles, 69); end
    bus_read(9'd256, d);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL skip5_entry0 got=%h exp=%h", d, 32'd5); end
    bus_read(9'd287, d);
    n_checks++; if (d !== 32'd36) begin n_fail++; $display("FAIL skip5_entry31 got=%h exp=%h", d, 32'd36); end
    bus_read(9'd319, d);
    n_checks++; if (d !== 32'd68) begin n_fail++; $display("FAIL skip5_entry63 got=%h exp=%h", d, 32'd68); end
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0000_4002) begin n_fail++; $display("FAIL skip5_status got=%h exp=%h", d, 32'h0000_4002); end
    bus_write(9'd2, 32'd0);
  endtask

  task automatic test_clear_restart;
    logic [31:0] d;
    bus_write(9'd0, 32'h1);
    for (int i = 0; i < 20; i++) begin
      data_in = 32'h100 + 32'(i);
      @(negedge div_clock);
    end
    address = 9'd0; writedata = 32'h2; write = 1'b1; data_in = 32'h1FF;
    @(negedge div_clock); write = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got=%b exp=0", busy); end
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_status got=%h exp=%h", d, 32'h0); end
    for (int i = 0; i < 64; i++) begin
      bus_read(9'(256 + i), d);
      if (i < 20) begin
        n_checks++; if (d !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL clear_entry%0d got=%h exp=%h", i, d, 32'h100 + 32'(i)); end
      end else begin
        n_checks++; if (d !== 32'd5 + 32'(i)) begin n_fail++; $display("FAIL clear_keep%0d got=%h exp=%h", i, d, 32'd5 + 32'(i)); end
      end
    end
    bus_write(9'd0, 32'h3);
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clear_over_start got=%h exp=%h", d, 32'h0); end
    bus_write(9'd0, 32'h1);
    for (int i = 0; i < 64; i++) begin
      data_in = 32'h200 + 32'(i);
      read = (i == 5);
      write = (i == 10);
      address = (i == 5) ? 9'd1 : 9'd0;
      writedata = 32'h1;
      @(negedge div_clock);
      if (i == 5) begin
        n_checks++; if (readdata !== 32'h0000_0501) begin n_fail++; $display("FAIL restart_count got=%h exp=%h", readdata, 32'h0000_0501); end
      end
    end
    read = 1'b0; write = 1'b0;
    repeat (2) @(negedge div_clock);
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0000_4002) begin n_fail++; $display("FAIL restart_status got=%h exp=%h", d, 32'h0000_4002); end
    bus_read(9'd256, d);
    n_checks++; if (d !== 32'h200) begin n_fail++; $display("FAIL restart_entry0 got=%h exp=%h", d, 32'h200); end
    bus_read(9'd266, d);
    n_checks++; if (d !== 32'h20A) begin n_fail++; $display("FAIL start_ignored_entry10 got=%h exp=%h", d, 32'h20A); end
    bus_read(9'd319, d);
    n_checks++; if (d !== 32'h23F) begin n_fail++; $display("FAIL restart_entry63 got=%h exp=%h", d, 32'h23F); end
  endtask

  task automatic test_reset_mid_capture;
    logic [31:0] d;
    bus_write(9'd0, 32'h1);
    for (int i = 0; i < 10; i++) begin
      data_in = 32'h300 + 32'(i);
      write = (i == 3);
      address = 9'd2;
      writedata = 32'h77;
      @(negedge div_clock);
    end
    write = 1'b0;
    reset = 1'b1; data_in = 32'h3FF;
    @(negedge div_clock);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    bus_read(9'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_status got=%h exp=%h", d, 32'h0); end
    bus_read(9'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_skip got=%h exp=%h", d, 32'h0); end
    for (int i = 0; i < 64; i++) begin
      bus_read(9'(256 + i), d);
      if (i < 10) begin
        n_checks++; if (d !== 32'h300 + 32'(i)) begin n_fail++; $display("FAIL rstmid_entry%0d got=%h exp=%h", i, d, 32'h300 + 32'(i)); end
      end else begin
        n_checks++; if (d !== 32'h200 + 32'(i)) begin n_fail++; $display("FAIL rstmid_keep%0d got=%h exp=%h", i, d, 32'h200 + 32'(i)); end
      end
    end
  endtask

  task automatic test_width12;
    logic [31:0] d;
    data_w12 = 12'hFFF;
    bus_write(9'd0, 32'h1);
    repeat (40) @(negedge div_clock);
    bus_read(9'd1, d);
    n_checks++; if (readdata_w12 !== 32'h0000_2002) begin n_fail++; $display("FAIL w12_status got=%h exp=%h", readdata_w12, 32'h0000_2002); end
    bus_read(9'd256, d);
    n_checks++; if (readdata_w12 !== 32'h0000_0FFF) begin n_fail++; $display("FAIL w12_entry0 got=%h exp=%h", readdata_w12, 32'h0000_0FFF); end
    bus_read(9'd287, d);
    n_checks++; if (readdata_w12 !== 32'h0000_0FFF) begin n_fail++; $display("FAIL w12_entry31 got=%h exp=%h", readdata_w12, 32'h0000_0FFF); end
    bus_read(9'd300, d);
    n_checks++; if (readdata_w12 !== 32'h0) begin n_fail++; $display("FAIL w12_addr300 got=%h exp=%h", readdata_w12, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_reg_access();
    test_skip0_ramp();
    test_skip5();
    test_clear_restart();
    test_reset_mid_capture();
    test_width12();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_result_capture.md
MC_RESULT_CAPTURE -- requirements
Module: mc_result_capture

Interface
REQ-001 Parameter WIDTH, default 32: width of the captured sample; legal range 1..32.
REQ-002 Parameter DEPTH, default 64: number of sample buffer entries; power of two, 2..256.
REQ-003 div_clock  in  1: the only clock; all logic on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 data_in  in  WIDTH: output of the upstream multicycle delay stage; sampled every div_clock cycle.
REQ-006 address  in  9: Avalon-MM word address.
REQ-007 read  in  1: Avalon-MM read strobe.
REQ-008 write  in  1: Avalon-MM write strobe.
REQ-009 writedata  in  32: Avalon-MM write data.
REQ-010 readdata  out  32: Avalon-MM read data; fixed read latency 1.
REQ-011 busy  out  1: high in ARMED or CAPTURE.

Function
REQ-012 Register map: addr 0 CTRL (W: bit0 start, bit1 clear); addr 1 STATUS (R: bit0 busy, bit1 done, bits[16:8] count); addr 2 SKIP (R/W, 16 bits); addr 256+i buffer entry i (R, i<DEPTH); all other addresses read 0.
REQ-013 FSM states: IDLE, ARMED, CAPTURE, DONE.
REQ-014 IDLE -> ARMED on a CTRL write with bit0=1; skip counter loads SKIP and count clears to 0 in the same cycle.
REQ-015 ARMED: skip counter decrements once per cycle; ARMED -> CAPTURE in the cycle the counter is 0; SKIP=0 means the first CAPTURE cycle immediately follows the start-write cycle.
REQ-016 CAPTURE: each cycle writes data_in to entry count and increments count; after entry DEPTH-1 is written, the FSM goes to DONE, with count=DEPTH.
REQ-017 DONE: done=1; captured data stays frozen; a start from DONE re-arms exactly as from IDLE.
REQ-018 CTRL write with bit1=1 from any state: FSM -> IDLE, count=0, done=0; buffer contents are unchanged; clear takes priority over start in the same write.
REQ-019 A start write while in ARMED or CAPTURE is ignored.
REQ-020 Buffer reads return the entry zero-extended to 32 bits, one cycle after read; a read during CAPTURE returns whatever the entry currently holds, with no stall.
REQ-021 Simultaneous read and write in one cycle: the write takes effect and readdata reflects the pre-write register value.
REQ-022 readdata holds its last value when read is low.
REQ-023 count width is clog2(DEPTH)+1; there is no wrap past DEPTH.

Reset
REQ-024 Reset drives: FSM=IDLE, SKIP=0, count=0, done=0, skip counter=0, readdata=0, busy=0.
REQ-025 Buffer RAM is not reset; its contents are undefined until the first capture.
REQ-026 Reset asserted mid-CAPTURE aborts the capture immediately; no further buffer writes occur.

Structure
REQ-027 Register addresses, CTRL bit positions and FSM state encoding live in shared package mc_capture_pkg.
REQ-028 Sample storage is one sub-module, mc_capture_ram: simple dual-port, 1 write port and 1 registered read port, inferable as block RAM.
REQ-029 FSM, counters and Avalon decode stay in the top module, with no additional clocks.

Verification
REQ-030 Reset, then read STATUS -> 0x00000000; read SKIP -> 0.
REQ-031 SKIP=0, data_in=ramp starting at 0x10 on the cycle after the start write -> entries 0..63 = 0x10..0x4F; STATUS=0x00004002.
REQ-032 SKIP=5, ramp 0..N -> entry 0 = ramp value 5 cycles after the cycle following the start write; busy high for exactly 5+64 cycles.
REQ-033 Clear written at count=20, then start -> count restarts at 0; entries 20..63 keep their old values until they are overwritten.
REQ-034 Reset pulse mid-CAPTURE at count=10 -> STATUS=0 afterwards; entries 10..63 are unchanged from their pre-capture contents.
REQ-035 WIDTH=12, data_in=0xFFF -> buffer reads return 0x00000FFF; a read of address 300 returns 0.
